// File: rtl/re_pkg.sv
// Shared definitions for the resource-element symbol scheduler: FSM state
// encoding, slot geometry constants and configuration sanity helpers.
package re_pkg;

    localparam int TOTAL_SC   = 1200;
    localparam int SC_PER_RB  = 12;
    localparam int N_SYM_SLOT = 14;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_WAIT_SRC = 3'd2,
        ST_START    = 3'd3,
        ST_MAP      = 3'd4,
        ST_NEXT     = 3'd5,
        ST_DONE     = 3'd6
    } sched_state_e;

    // One past the last allocated subcarrier, computed at 12 bits so the
    // worst case (2047 + 127*12 = 3571) never wraps.
    function automatic logic [11:0] alloc_end(input logic [10:0] n_sc,
                                              input logic [6:0]  n_rb);
        return {1'b0, n_sc} + ({5'd0, n_rb} * 12'(SC_PER_RB));
    endfunction

    // True when a latched slot configuration cannot be scheduled.
    function automatic logic cfg_invalid(input logic [3:0]  sym_start,
                                         input logic [3:0]  sym_end,
                                         input logic [10:0] n_sc,
                                         input logic [6:0]  n_rb);
        return (sym_start > sym_end)
            || (sym_end > 4'(N_SYM_SLOT - 1))
            || (n_rb == 7'd0)
            || (alloc_end(n_sc, n_rb) > 12'(TOTAL_SC));
    endfunction

endpackage

// File: rtl/re_sched_timer.sv
// Per-state wait timer: cleared while idle-side states run, counts every
// cycle the scheduler waits, and flags expiry on the cycle whose increment
// would bring the count to TO_MAX.
module re_sched_timer
    import re_pkg::*;
#(
    parameter int              TO_W   = 16,
    parameter logic [TO_W-1:0] TO_MAX = 16'd4095
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [TO_W-1:0] count_q;

    assign expire_o = en_i && (count_q == (TO_MAX - TO_W'(1)));

    // Wait-cycle counter: clear has priority over counting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + TO_W'(1);
        end else begin
            count_q <= count_q;
        end
    end

endmodule

// File: rtl/re_symbol_scheduler.sv
// PUSCH slot scheduler: accepts a slot configuration, validates it, then
// launches the RE mapper once per symbol from Sym_Start to Sym_End, waiting
// for the DMRS or FFT source of each symbol and guarding every wait with a
// timeout. All outputs are registered.
module re_symbol_scheduler
    import re_pkg::*;
#(
    parameter int              TO_W   = 16,
    parameter logic [TO_W-1:0] TO_MAX = 16'd4095
) (
    input  logic        CLK_RE,
    input  logic        RST_RE,
    input  logic        Cfg_Valid,
    output logic        Cfg_Ready,
    input  logic [10:0] N_sc,
    input  logic [6:0]  N_rb,
    input  logic [3:0]  Sym_Start,
    input  logic [3:0]  Sym_End,
    input  logic [13:0] Dmrs_Mask,
    input  logic        DMRS_Done,
    input  logic        FFT_Done,
    input  logic        Map_Sym_Done,
    input  logic        Abort,
    output logic        Map_Start,
    output logic        Map_Is_Dmrs,
    output logic [3:0]  Map_Sym,
    output logic [10:0] Map_N_sc,
    output logic [6:0]  Map_N_rb,
    output logic        Busy,
    output logic        Slot_Done,
    output logic        Cfg_Err,
    output logic        Timeout_Err
);

    sched_state_e state_q, state_d;

    logic        cfg_ready_q, busy_q, map_start_q, slot_done_q;
    logic        cfg_err_q, timeout_err_q, map_is_dmrs_q;
    logic [10:0] n_sc_q;
    logic [6:0]  n_rb_q;
    logic [3:0]  sym_start_q, sym_end_q, map_sym_q;
    logic [13:0] dmrs_mask_q;

    logic handshake_s, cfg_bad_s, src_rdy_s, timeout_s;
    logic tmr_en_s, tmr_clr_s, tmr_expire_s;

    assign handshake_s = (state_q == ST_IDLE) && Cfg_Valid && cfg_ready_q && !Abort;
    assign cfg_bad_s   = cfg_invalid(sym_start_q, sym_end_q, n_sc_q, n_rb_q);
    assign src_rdy_s   = dmrs_mask_q[map_sym_q] ? DMRS_Done : FFT_Done;

    // The counter runs only while waiting; any other state holds it clear,
    // so it starts from zero on every entry into WAIT_SRC or MAP.
    assign tmr_en_s  = (state_q == ST_WAIT_SRC) || (state_q == ST_MAP);
    assign tmr_clr_s = !tmr_en_s;

    // Forward progress wins over an expiring timer in the same cycle.
    assign timeout_s = !Abort && tmr_expire_s &&
                       (((state_q == ST_WAIT_SRC) && !src_rdy_s) ||
                        ((state_q == ST_MAP) && !Map_Sym_Done));

    re_sched_timer #(
        .TO_W   (TO_W),
        .TO_MAX (TO_MAX)
    ) u_timer (
        .clk_i    (CLK_RE),
        .rst_i    (RST_RE),
        .clr_i    (tmr_clr_s),
        .en_i     (tmr_en_s),
        .expire_o (tmr_expire_s)
    );

    // Next-state decode; Abort overrides everything else.
    always_comb begin
        state_d = state_q;
        if (Abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Cfg_Valid && cfg_ready_q) state_d = ST_CHECK;
                    else                          state_d = ST_IDLE;
                end
                ST_CHECK: begin
                    if (cfg_bad_s) state_d = ST_IDLE;
                    else           state_d = ST_WAIT_SRC;
                end
                ST_WAIT_SRC: begin
                    if (src_rdy_s)         state_d = ST_START;
                    else if (tmr_expire_s) state_d = ST_IDLE;
                    else                   state_d = ST_WAIT_SRC;
                end
                ST_START: state_d = ST_MAP;
                ST_MAP: begin
                    if (Map_Sym_Done)      state_d = ST_NEXT;
                    else if (tmr_expire_s) state_d = ST_IDLE;
                    else                   state_d = ST_MAP;
                end
                ST_NEXT: begin
                    if (map_sym_q == sym_end_q) state_d = ST_DONE;
                    else                        state_d = ST_WAIT_SRC;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state and registered status/pulse outputs.
    always_ff @(posedge CLK_RE) begin
        if (RST_RE) begin
            state_q       <= ST_IDLE;
            cfg_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            map_start_q   <= 1'b0;
            slot_done_q   <= 1'b0;
            cfg_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_ready_q   <= (state_d == ST_IDLE);
            busy_q        <= (state_d != ST_IDLE);
            map_start_q   <= (state_q == ST_START) && !Abort;
            slot_done_q   <= (state_q == ST_DONE) && !Abort;
            cfg_err_q     <= (state_q == ST_CHECK) && cfg_bad_s && !Abort;
            timeout_err_q <= timeout_s;
        end
    end

    // Slot configuration capture and per-symbol pointer / type tracking.
    always_ff @(posedge CLK_RE) begin
        if (RST_RE) begin
            n_sc_q        <= 11'd0;
            n_rb_q        <= 7'd0;
            sym_start_q   <= 4'd0;
            sym_end_q     <= 4'd0;
            dmrs_mask_q   <= 14'd0;
            map_sym_q     <= 4'd0;
            map_is_dmrs_q <= 1'b0;
        end else begin
            if (handshake_s) begin
                n_sc_q      <= N_sc;
                n_rb_q      <= N_rb;
                sym_start_q <= Sym_Start;
                sym_end_q   <= Sym_End;
                dmrs_mask_q <= Dmrs_Mask;
            end
            if (!Abort && (state_q == ST_CHECK) && !cfg_bad_s) begin
                map_sym_q <= sym_start_q;
            end else if (!Abort && (state_q == ST_NEXT) && (map_sym_q != sym_end_q)) begin
                map_sym_q <= map_sym_q + 4'd1;
            end
            if (!Abort && (state_q == ST_START)) begin
                map_is_dmrs_q <= dmrs_mask_q[map_sym_q];
            end
        end
    end

    assign Cfg_Ready   = cfg_ready_q;
    assign Busy        = busy_q;
    assign Map_Start   = map_start_q;
    assign Slot_Done   = slot_done_q;
    assign Cfg_Err     = cfg_err_q;
    assign Timeout_Err = timeout_err_q;
    assign Map_Is_Dmrs = map_is_dmrs_q;
    assign Map_Sym     = map_sym_q;
    assign Map_N_sc    = n_sc_q;
    assign Map_N_rb    = n_rb_q;

endmodule

// File: tb/tb_re_symbol_scheduler.sv
// Directed self-checking bench for re_symbol_scheduler. Inputs change and
// outputs are sampled on the falling clock edge; offsets are counted in
// cycles after the handshake edge.
module tb_re_symbol_scheduler;

    logic        CLK_RE = 1'b0;
    logic        RST_RE, Cfg_Valid, DMRS_Done, FFT_Done, Map_Sym_Done, Abort;
    logic [10:0] N_sc;
    logic [6:0]  N_rb;
    logic [3:0]  Sym_Start, Sym_End;
    logic [13:0] Dmrs_Mask;
    logic        Cfg_Ready, Map_Start, Map_Is_Dmrs, Busy, Slot_Done, Cfg_Err, Timeout_Err;
    logic [3:0]  Map_Sym;
    logic [10:0] Map_N_sc;
    logic [6:0]  Map_N_rb;

    always #5 CLK_RE = ~CLK_RE;

    re_symbol_scheduler #(.TO_W(16), .TO_MAX(16'd10)) dut (
        .CLK_RE(CLK_RE), .RST_RE(RST_RE), .Cfg_Valid(Cfg_Valid), .Cfg_Ready(Cfg_Ready),
        .N_sc(N_sc), .N_rb(N_rb), .Sym_Start(Sym_Start), .Sym_End(Sym_End),
        .Dmrs_Mask(Dmrs_Mask), .DMRS_Done(DMRS_Done), .FFT_Done(FFT_Done),
        .Map_Sym_Done(Map_Sym_Done), .Abort(Abort), .Map_Start(Map_Start),
        .Map_Is_Dmrs(Map_Is_Dmrs), .Map_Sym(Map_Sym), .Map_N_sc(Map_N_sc),
        .Map_N_rb(Map_N_rb), .Busy(Busy), .Slot_Done(Slot_Done), .Cfg_Err(Cfg_Err),
        .Timeout_Err(Timeout_Err)
    );

    int checks_cnt = 0;
    int errors_cnt = 0;

    int          n_start, n_done, n_cfg, n_to;
    int          start_off, done_off, cfg_off, to_off, idle_off;
    logic [15:0] sym_log;
    logic [3:0]  dmrs_log;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a configuration for one edge; returns on the falling edge of
    // the cycle right after the handshake (offset 0).
    task automatic do_handshake(input logic [10:0] sc, input logic [6:0] rb,
                                input logic [3:0] s0, input logic [3:0] s1,
                                input logic [13:0] mask);
        @(negedge CLK_RE);
        N_sc = sc; N_rb = rb; Sym_Start = s0; Sym_End = s1; Dmrs_Mask = mask;
        Cfg_Valid = 1'b1;
        @(negedge CLK_RE);
        Cfg_Valid = 1'b0;
    endtask

    // Watch ncyc cycles, acting as the mapper (done 2 cycles after each
    // Map_Start), optionally aborting together with the first done, and
    // optionally driving RST_RE during cycle rst_at.
    task automatic observe(input int ncyc, input bit abort_on_done, input int rst_at);
        int resp;
        resp = 0;
        n_start = 0; n_done = 0; n_cfg = 0; n_to = 0;
        start_off = -1; done_off = -1; cfg_off = -1; to_off = -1; idle_off = -1;
        sym_log = 16'h0000; dmrs_log = 4'b0000;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge CLK_RE);
            if (Map_Start) begin
                n_start++;
                if (start_off < 0) start_off = c;
                sym_log  = {sym_log[11:0], Map_Sym};
                dmrs_log = {dmrs_log[2:0], Map_Is_Dmrs};
            end
            if (Slot_Done)   begin n_done++; done_off = c; end
            if (Cfg_Err)     begin n_cfg++;  cfg_off  = c; end
            if (Timeout_Err) begin n_to++;   to_off   = c; end
            if (Cfg_Ready && idle_off < 0) idle_off = c;
            Map_Sym_Done = 1'b0;
            Abort        = 1'b0;
            RST_RE       = (c == rst_at);
            if (resp > 0) begin
                resp--;
                if (resp == 0) begin
                    Map_Sym_Done = 1'b1;
                    if (abort_on_done) Abort = 1'b1;
                end
            end
            if (Map_Start) resp = 2;
        end
        Map_Sym_Done = 1'b0;
        Abort        = 1'b0;
    endtask

    logic [10:0] bad_sc [4] = '{11'd1190, 11'd0, 11'd0, 11'd0};
    logic [6:0]  bad_rb [4] = '{7'd1,     7'd4,  7'd4,  7'd0};
    logic [3:0]  bad_s0 [4] = '{4'd0,     4'd4,  4'd2,  4'd0};
    logic [3:0]  bad_s1 [4] = '{4'd3,     4'd3,  4'd14, 4'd3};

    initial begin
        RST_RE = 1'b1; Cfg_Valid = 1'b0; DMRS_Done = 1'b0; FFT_Done = 1'b0;
        Map_Sym_Done = 1'b0; Abort = 1'b0; N_sc = 11'd0; N_rb = 7'd0;
        Sym_Start = 4'd0; Sym_End = 4'd0; Dmrs_Mask = 14'd0;
        repeat (2) @(negedge CLK_RE);
        check_val("rst_ready", 32'(Cfg_Ready), 32'd1);
        check_val("rst_busy",  32'(Busy),      32'd0);
        check_val("rst_start", 32'(Map_Start), 32'd0);
        check_val("rst_nrb",   32'(Map_N_rb),  32'd0);
        RST_RE = 1'b0;

        // Four-symbol slot, DMRS on symbol 0.
        DMRS_Done = 1'b1; FFT_Done = 1'b1;
        do_handshake(11'd0, 7'd4, 4'd0, 4'd3, 14'h0001);
        check_val("hs_busy",  32'(Busy),      32'd1);
        check_val("hs_ready", 32'(Cfg_Ready), 32'd0);
        check_val("hs_nrb",   32'(Map_N_rb),  32'd4);
        observe(30, 1'b0, -1);
        check_val("t1_latency", start_off, 32'd3);
        check_val("t1_nstart",  n_start,   32'd4);
        check_val("t1_syms",    32'(sym_log),  32'h0123);
        check_val("t1_dmrs",    32'(dmrs_log), 32'h8);
        check_val("t1_ndone",   n_done,    32'd1);
        check_val("t1_doneoff", done_off,  32'd26);
        check_val("t1_errs",    n_cfg + n_to, 32'd0);

        // Rejected configurations: overflow 1202, start>end, end>13, zero RBs.
        for (int i = 0; i < 4; i++) begin
            do_handshake(bad_sc[i], bad_rb[i], bad_s0[i], bad_s1[i], 14'h0000);
            observe(4, 1'b0, -1);
            check_val($sformatf("bad%0d_cfgoff", i), cfg_off,  32'd1);
            check_val($sformatf("bad%0d_ncfg", i),   n_cfg,    32'd1);
            check_val($sformatf("bad%0d_nstart", i), n_start,  32'd0);
            check_val($sformatf("bad%0d_idle", i),   idle_off, 32'd1);
            check_val($sformatf("bad%0d_ready", i),  32'(Cfg_Ready), 32'd1);
        end

        // Single symbol 5, allocation ending exactly at 1200; Cfg_Valid with
        // other values held high mid-slot must not disturb the latched config.
        do_handshake(11'd1188, 7'd1, 4'd5, 4'd5, 14'h0000);
        N_sc = 11'd5; N_rb = 7'd9; Cfg_Valid = 1'b1;
        observe(8, 1'b0, -1);
        check_val("t3_nrb",     32'(Map_N_rb), 32'd1);
        check_val("t3_nsc",     32'(Map_N_sc), 32'd1188);
        Cfg_Valid = 1'b0;
        check_val("t3_nstart",  n_start,   32'd1);
        check_val("t3_sym",     32'(sym_log),  32'h0005);
        check_val("t3_dmrs",    32'(dmrs_log), 32'h0);
        check_val("t3_doneoff", done_off,  32'd8);
        check_val("t3_ncfg",    n_cfg,     32'd0);

        // FFT source never ready: timeout 10 cycles after WAIT_SRC entry (offset 1).
        FFT_Done = 1'b0;
        do_handshake(11'd0, 7'd1, 4'd0, 4'd0, 14'h0000);
        observe(15, 1'b0, -1);
        check_val("t4_tooff",  to_off,   32'd11);
        check_val("t4_nto",    n_to,     32'd1);
        check_val("t4_idle",   idle_off, 32'd11);
        check_val("t4_ndone",  n_done,   32'd0);
        check_val("t4_nstart", n_start,  32'd0);
        FFT_Done = 1'b1;

        // Abort together with Map_Sym_Done on the first symbol.
        do_handshake(11'd0, 7'd4, 4'd0, 4'd3, 14'h0001);
        observe(12, 1'b1, -1);
        check_val("t5_idle",   idle_off, 32'd6);
        check_val("t5_nstart", n_start,  32'd1);
        check_val("t5_ndone",  n_done,   32'd0);
        check_val("t5_errs",   n_cfg + n_to, 32'd0);

        // Reset during symbol 2, then a clean slot.
        do_handshake(11'd0, 7'd4, 4'd0, 4'd3, 14'h0001);
        observe(16, 1'b0, 16);
        check_val("t6_pre_nstart", n_start, 32'd3);
        @(negedge CLK_RE);
        RST_RE = 1'b0;
        check_val("t6_ready", 32'(Cfg_Ready), 32'd1);
        check_val("t6_busy",  32'(Busy),      32'd0);
        check_val("t6_start", 32'(Map_Start), 32'd0);
        check_val("t6_sym",   32'(Map_Sym),   32'd0);
        check_val("t6_nrb",   32'(Map_N_rb),  32'd0);
        check_val("t6_done",  32'(Slot_Done), 32'd0);
        do_handshake(11'd0, 7'd4, 4'd0, 4'd3, 14'h0001);
        observe(30, 1'b0, -1);
        check_val("t6_nstart",  n_start,  32'd4);
        check_val("t6_syms",    32'(sym_log), 32'h0123);
        check_val("t6_doneoff", done_off, 32'd26);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/re_symbol_scheduler.md
RE_SYMBOL_SCHEDULER -- requirements
Module: re_symbol_scheduler

Interface
REQ-001 SHALL have parameter TO_W, default 16, timeout counter width.
REQ-002 SHALL have parameter TO_MAX, default 16'd4095, maximum wait cycles per state.
REQ-003 CLK_RE  in  1  sole clock; all logic on its rising edge.
REQ-004 RST_RE  in  1  reset, synchronous, active-high.
REQ-005 Cfg_Valid / Cfg_Ready  in/out  1/1  slot-configuration handshake.
REQ-006 N_sc  in  11  first subcarrier; N_rb  in  7  allocated RBs; both latched on handshake.
REQ-007 Sym_Start, Sym_End  in  4/4  first and last PUSCH symbol; latched on handshake.
REQ-008 Dmrs_Mask  in  14  bit i=1 means symbol i is DMRS; latched on handshake.
REQ-009 DMRS_Done, FFT_Done  in  1/1  level inputs: DMRS sequence ready; FFT output of current symbol ready.
REQ-010 Map_Sym_Done  in  1  mapper finished current symbol.
REQ-011 Abort  in  1  cancel slot.
REQ-012 Map_Start  out  1  one-cycle pulse launching the mapper on one symbol.
REQ-013 Map_Is_Dmrs, Map_Sym  out  1/4  type and index of the launched symbol.
REQ-014 Map_N_sc, Map_N_rb  out  11/7  latched allocation, stable from handshake until return to IDLE.
REQ-015 Busy, Slot_Done, Cfg_Err, Timeout_Err  out  1 each; the last three are one-cycle pulses.

Function
REQ-016 States SHALL be IDLE, CHECK, WAIT_SRC, START, MAP, NEXT, DONE.
REQ-017 Cfg_Ready SHALL be 1 only in IDLE; a handshake occurs when Cfg_Valid && Cfg_Ready at an edge, which moves the FSM to CHECK.
REQ-018 CHECK SHALL last one cycle and fail if Sym_Start>Sym_End, Sym_End>13, N_rb==0, or N_sc+12*N_rb>1200 (computed at 12 bits, no truncation).
REQ-019 On failure, CHECK SHALL pulse Cfg_Err and go to IDLE; on pass, it SHALL set Map_Sym=Sym_Start and go to WAIT_SRC.
REQ-020 WAIT_SRC SHALL go to START when Dmrs_Mask[Map_Sym] ? DMRS_Done : FFT_Done is 1.
REQ-021 START SHALL assert Map_Start for exactly one cycle with Map_Is_Dmrs=Dmrs_Mask[Map_Sym], then go to MAP.
REQ-022 Map_Sym_Done SHALL be sampled only in MAP; when it is 1, the FSM SHALL go to NEXT.
REQ-023 NEXT SHALL go to DONE if Map_Sym==Sym_End; otherwise it SHALL set Map_Sym=Map_Sym+1 and go to WAIT_SRC.
REQ-024 DONE SHALL pulse Slot_Done for one cycle and go to IDLE.
REQ-025 Minimum latency SHALL be: handshake at edge k, Map_Start high in cycle k+3 when the source is already ready.
REQ-026 A timeout counter SHALL clear on entry to WAIT_SRC or MAP and increment each cycle spent there.
REQ-027 When the timeout counter reaches TO_MAX, the FSM SHALL pulse Timeout_Err and go to IDLE with no Slot_Done.
REQ-028 Abort SHALL move any state to IDLE on the next edge, with no Slot_Done and no error pulse; Abort has priority over timeout and over Map_Sym_Done.
REQ-029 Busy SHALL be 1 in every state except IDLE.
REQ-030 Cfg_Valid outside IDLE SHALL be ignored, and latched config SHALL NOT change.
REQ-031 A single-symbol slot (Sym_Start==Sym_End) SHALL produce exactly one Map_Start and then Slot_Done.

Reset
REQ-032 RST_RE high at an edge SHALL force IDLE, clear the timeout counter, and set all outputs to 0 except Cfg_Ready=1, including mid-slot.
REQ-033 All latched configuration registers SHALL reset to 0.

Structure
REQ-034 State encoding, TOTAL_SC=1200, SC_PER_RB=12 and N_SYM_SLOT=14 SHALL reside in shared package re_pkg.
REQ-035 The timeout counter SHALL be a sub-module re_sched_timer (clear, enable, TO_MAX compare, expire flag).

Verification
REQ-036 N_sc=0, N_rb=4, Sym 0..3, mask 0x0001, DMRS_Done and FFT_Done held 1, Map_Sym_Done returned 2 cycles after each Map_Start -> four Map_Start with Map_Sym 0,1,2,3, Map_Is_Dmrs 1,0,0,0, then one Slot_Done.
REQ-037 N_sc=1190, N_rb=1 (total 1202) -> Cfg_Err one cycle after the handshake, no Map_Start, Cfg_Ready=1 afterwards.
REQ-038 Sym_Start=5, Sym_End=5 -> exactly one Map_Start with Map_Sym=5, then Slot_Done.
REQ-039 FFT_Done held 0 with TO_MAX=10 -> Timeout_Err pulses 10 cycles after WAIT_SRC entry, FSM returns to IDLE, no Slot_Done.
REQ-040 Abort asserted in the same cycle as Map_Sym_Done in MAP -> IDLE next cycle, no NEXT state, no Slot_Done.
REQ-041 RST_RE pulsed in the middle of symbol 2 -> all outputs 0 and Cfg_Ready=1 the next cycle; a new slot then runs normally.
